// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined comparator for the exception-tagged FP format.
// Produces A <mode> B, an unordered flag, and min/max of the operand pair.
module fp_compare_pipe #(
  parameter int WE = 5,
  parameter int WF = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WE+WF+2:0]   inA,
  input  logic [WE+WF+2:0]   inB,
  input  logic [2:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               result,
  output logic               unordered,
  output logic [WE+WF+2:0]   min_out,
  output logic [WE+WF+2:0]   max_out
);

  localparam int W  = WE + WF + 3;
  localparam int MW = WE + WF;

  localparam logic [2:0] MODE_LT = 3'd0;
  localparam logic [2:0] MODE_LE = 3'd1;
  localparam logic [2:0] MODE_EQ = 3'd2;
  localparam logic [2:0] MODE_GE = 3'd3;
  localparam logic [2:0] MODE_GT = 3'd4;
  localparam logic [2:0] MODE_NE = 3'd5;

  localparam logic [W-1:0] CANON_NAN = {2'b11, {(W-2){1'b0}}};

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Rank: -inf=0, neg normal=1, zero=2, pos normal=3, +inf=4 (NaN handled separately)
  logic [W-1:0] opnd_w [2];
  logic [2:0]   rank_w [2];
  logic [1:0]   nan_w;

  assign opnd_w[0] = inA;
  assign opnd_w[1] = inB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      logic [1:0] exc;
      logic       sgn;
      assign exc        = opnd_w[gi][W-1:W-2];
      assign sgn        = opnd_w[gi][W-3];
      assign nan_w[gi]  = (exc == 2'b11);
      assign rank_w[gi] = (exc == 2'b01) ? (sgn ? 3'd1 : 3'd3) :
                          (exc == 2'b10) ? (sgn ? 3'd0 : 3'd4) : 3'd2;
    end
  endgenerate

  logic [MW-1:0] mag_a;
  logic [MW-1:0] mag_b;
  logic          mag_lt;
  logic          mag_eq;
  logic          same_rank;
  logic          lt_next;
  logic          eq_next;

  assign mag_a = inA[MW-1:0];
  assign mag_b = inB[MW-1:0];

  always_comb begin
    mag_lt    = (mag_a < mag_b);
    mag_eq    = (mag_a == mag_b);
    same_rank = (rank_w[0] == rank_w[1]);
    lt_next   = 1'b0;
    if (!same_rank)
      lt_next = (rank_w[0] < rank_w[1]);
    else if (rank_w[0] == 3'd1)
      lt_next = !mag_lt && !mag_eq;
    else if (rank_w[0] == 3'd3)
      lt_next = mag_lt;
    eq_next = same_rank && (mag_eq || (rank_w[0] != 3'd1 && rank_w[0] != 3'd3));
  end

  // Stage 1: classification and magnitude compare
  logic         s1_valid_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [2:0]   mode_reg;
  logic         nan_reg;
  logic         lt_reg;
  logic         eq_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      mode_reg     <= '0;
      nan_reg      <= 1'b0;
      lt_reg       <= 1'b0;
      eq_reg       <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= in_valid & in_ready;
      if (in_valid) begin
        a_reg    <= inA;
        b_reg    <= inB;
        mode_reg <= mode;
        nan_reg  <= |nan_w;
        lt_reg   <= lt_next;
        eq_reg   <= eq_next;
      end
    end
  end

  logic         res_next;
  logic [W-1:0] min_next;
  logic [W-1:0] max_next;
  logic         zero_pair;

  always_comb begin
    res_next = 1'b0;
    case (mode_reg)
      MODE_LT: res_next = lt_reg;
      MODE_LE: res_next = lt_reg | eq_reg;
      MODE_EQ: res_next = eq_reg;
      MODE_GE: res_next = ~lt_reg;
      MODE_GT: res_next = ~lt_reg & ~eq_reg;
      MODE_NE: res_next = ~eq_reg;
      default: res_next = 1'b0;
    endcase
    if (nan_reg)
      res_next = (mode_reg == MODE_NE);

    zero_pair = (a_reg[W-1:W-2] == 2'b00) && (b_reg[W-1:W-2] == 2'b00) &&
                (a_reg[W-3] != b_reg[W-3]);
    min_next = a_reg;
    max_next = a_reg;
    if (nan_reg) begin
      min_next = CANON_NAN;
      max_next = CANON_NAN;
    end else if (lt_reg) begin
      max_next = b_reg;
    end else if (!eq_reg) begin
      min_next = b_reg;
    end else if (zero_pair) begin
      // Opposite-signed zeros: negative one is the minimum
      min_next = a_reg[W-3] ? a_reg : b_reg;
      max_next = a_reg[W-3] ? b_reg : a_reg;
    end
  end

  // Stage 2: mode-applied result and min/max
  logic         out_valid_reg;
  logic         result_reg;
  logic         unordered_reg;
  logic [W-1:0] min_reg;
  logic [W-1:0] max_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= 1'b0;
      unordered_reg <= 1'b0;
      min_reg       <= '0;
      max_reg       <= '0;
    end else if (adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg    <= res_next;
        unordered_reg <= nan_reg;
        min_reg       <= min_next;
        max_reg       <= max_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign unordered = unordered_reg;
  assign min_out   = min_reg;
  assign max_out   = max_reg;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed cases, stall/back-to-back,
// mid-flight reset and randomized traffic against a real-valued reference model.
module tb_fp_compare_pipe;

  localparam int WE = 5;
  localparam int WF = 8;
  localparam int W  = WE + WF + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic [2:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         result;
  logic         unordered;
  logic [W-1:0] min_out;
  logic [W-1:0] max_out;

  always #5 clk = ~clk;

  fp_compare_pipe #(.WE(WE), .WF(WF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .unordered(unordered),
    .min_out(min_out), .max_out(max_out)
  );

  typedef struct packed {
    logic         res;
    logic         unord;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rand_done;

  localparam logic [W-1:0] CNAN = {2'b11, {(W-2){1'b0}}};

  function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                      input logic [WE-1:0] e, input logic [WF-1:0] f);
    return {exc, s, e, f};
  endfunction

  // Numeric value of an operand; infinities sit far beyond any normal
  function automatic real value_of(input logic [W-1:0] x);
    logic [WE-1:0] ev;
    logic [WF-1:0] fv;
    real           mag;
    ev = x[W-4:WF];
    fv = x[WF-1:0];
    case (x[W-1:W-2])
      2'b01: begin
        mag = (1.0 + real'(fv) / real'(1 << WF)) * (2.0 ** (real'(ev) - real'((1 << (WE-1)) - 1)));
        return x[W-3] ? -mag : mag;
      end
      2'b10:   return x[W-3] ? -1.0e30 : 1.0e30;
      default: return 0.0;
    endcase
  endfunction

  function automatic txn_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m);
    txn_t t;
    real  va, vb;
    logic nan;
    nan = (a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11);
    va = value_of(a);
    vb = value_of(b);
    t.unord = nan;
    case (m)
      3'd0:    t.res = (va <  vb);
      3'd1:    t.res = (va <= vb);
      3'd2:    t.res = (va == vb);
      3'd3:    t.res = (va >= vb);
      3'd4:    t.res = (va >  vb);
      3'd5:    t.res = (va != vb);
      default: t.res = 1'b0;
    endcase
    if (nan) t.res = (m == 3'd5);
    if (nan) begin
      t.mn = CNAN; t.mx = CNAN;
    end else if (va < vb) begin
      t.mn = a; t.mx = b;
    end else if (va > vb) begin
      t.mn = b; t.mx = a;
    end else if (va == 0.0 && a[W-3] != b[W-3]) begin
      t.mn = a[W-3] ? a : b; t.mx = a[W-3] ? b : a;
    end else begin
      t.mn = a; t.mx = a;
    end
    return t;
  endfunction

  function automatic logic [W-1:0] rand_op();
    int r;
    logic [1:0] exc;
    r = $urandom_range(0, 9);
    exc = (r < 2) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    return mk(exc, 1'($urandom), WE'($urandom), WF'($urandom));
  endfunction

  always @(negedge clk)
    if (rst && out_valid && out_ready)
      obs_q.push_back({result, unordered, min_out, max_out});

  // Called at posedge+1; holds the pair until accepted, then queues its expectation
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m);
    bit ok = 1'b0;
    in_valid = 1'b1; inA = a; inB = b; mode = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL send_accept: in_ready stayed 0 for 200 cycles, required 1");
    else begin n_pass++; exp_q.push_back(model(a, b, m)); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, result, unordered} !== 4'b0100)
      $display("FAIL reset_ctrl: valid/ready/res/unord=%b required 0100",
               {out_valid, in_ready, result, unordered});
    else n_pass++;
    n_checks++;
    if (min_out !== '0 || max_out !== '0)
      $display("FAIL reset_minmax: min=%h max=%h required 0/0", min_out, max_out);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_latency();
    logic [W-1:0] p1, p2;
    p1 = mk(2'b01, 1'b0, 5'd15, 8'd0);
    p2 = mk(2'b01, 1'b0, 5'd16, 8'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; inA = p1; inB = p2; mode = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_1cyc: out_valid=%b required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, result, unordered, min_out, max_out} !== {1'b1, 1'b1, 1'b0, p1, p2})
      $display("FAIL latency_2cyc: valid=%b res=%b min=%h max=%h required 1 1 %h %h",
               out_valid, result, min_out, max_out, p1, p2);
    else n_pass++;
    $display("txn latency a=%h b=%h mode=0 res=%b", p1, p2, result);
    @(posedge clk); #1;
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL latency_count: delivered=%0d required 1", obs_q.size());
    else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8], tb[8];
    logic [2:0]   tm[8];
    logic         tr[8];
    txn_t e, o;
    int k = 0;
    ta[0] = mk(2'b01, 1'b1, 5'd16, 8'd128); tb[0] = mk(2'b01, 1'b1, 5'd16, 8'd64); tm[0] = 3'd4; tr[0] = 1'b0;
    ta[1] = ta[0];                          tb[1] = tb[0];                         tm[1] = 3'd1; tr[1] = 1'b1;
    ta[2] = mk(2'b00, 1'b0, 5'd0, 8'd0);    tb[2] = mk(2'b00, 1'b1, 5'd0, 8'd0);   tm[2] = 3'd2; tr[2] = 1'b1;
    ta[3] = mk(2'b11, 1'b1, 5'd5, 8'd7);    tb[3] = mk(2'b10, 1'b0, 5'd0, 8'd0);   tm[3] = 3'd0; tr[3] = 1'b0;
    ta[4] = ta[3];                          tb[4] = tb[3];                         tm[4] = 3'd2; tr[4] = 1'b0;
    ta[5] = ta[3];                          tb[5] = tb[3];                         tm[5] = 3'd5; tr[5] = 1'b1;
    ta[6] = mk(2'b01, 1'b0, 5'd3, 8'd1);    tb[6] = mk(2'b01, 1'b0, 5'd3, 8'd1);   tm[6] = 3'd6; tr[6] = 1'b0;
    ta[7] = mk(2'b10, 1'b1, 5'd9, 8'd9);    tb[7] = mk(2'b01, 1'b1, 5'd31, 8'd255); tm[7] = 3'd7; tr[7] = 1'b0;
    for (int i = 0; i < 8; i++) send(ta[i], tb[i], tm[i]);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e || o.res !== tr[k])
        $display("FAIL directed_%0d: res=%b unord=%b min=%h max=%h required %b %b %h %h",
                 k, o.res, o.unord, o.mn, o.mx, tr[k], e.unord, e.mn, e.mx);
      else n_pass++;
      $display("txn directed %0d a=%h b=%h mode=%0d res=%b min=%h max=%h",
               k, ta[k], tb[k], tm[k], o.res, o.mn, o.mx);
      k++;
    end
    n_checks++;
    if (k != 8 || obs_q.size() != 0)
      $display("FAIL directed_count: delivered=%0d required 8", k + obs_q.size());
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[4], tb[4];
    logic [2:0]   tm[4];
    txn_t e, o, snap;
    bit stalled = 1'b0;
    int idx = 0, k = 0;
    ta[0] = mk(2'b01, 1'b0, 5'd15, 8'd0);  tb[0] = mk(2'b01, 1'b0, 5'd16, 8'd0);  tm[0] = 3'd0;
    ta[1] = mk(2'b01, 1'b1, 5'd16, 8'd128); tb[1] = mk(2'b01, 1'b1, 5'd16, 8'd64); tm[1] = 3'd3;
    ta[2] = mk(2'b10, 1'b0, 5'd0, 8'd0);   tb[2] = mk(2'b10, 1'b1, 5'd0, 8'd0);   tm[2] = 3'd4;
    ta[3] = mk(2'b00, 1'b0, 5'd0, 8'd0);   tb[3] = mk(2'b01, 1'b0, 5'd16, 8'd0);  tm[3] = 3'd5;
    snap = '0;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 4) begin
        in_valid = 1'b1; inA = ta[idx]; inB = tb[idx]; mode = tm[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (!out_valid || {result, unordered, min_out, max_out} !== snap)
          $display("FAIL stall_hold_c%0d: valid=%b res=%b min=%h max=%h required 1 %b %h %h",
                   c, out_valid, result, min_out, max_out, snap.res, snap.mn, snap.mx);
        else n_pass++;
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        snap = {result, unordered, min_out, max_out};
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready_c%0d: in_ready=%b required 0", c, in_ready);
        else n_pass++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ta[idx], tb[idx], tm[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e)
        $display("FAIL b2b_%0d: res=%b min=%h max=%h required %b %h %h",
                 k, o.res, o.mn, o.mx, e.res, e.mn, e.mx);
      else n_pass++;
      $display("txn b2b %0d res=%b unord=%b min=%h max=%h", k, o.res, o.unord, o.mn, o.mx);
      k++;
    end
    n_checks++;
    if (k != 4 || idx != 4 || obs_q.size() != 0)
      $display("FAIL b2b_count: delivered=%0d accepted=%0d required 4", k + obs_q.size(), idx);
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    txn_t e, o;
    int k = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [W-1:0] a, b;
          int sel;
          a = rand_op();
          sel = $urandom_range(0, 3);
          if (sel == 0) b = a;
          else if (sel == 1) b = {a[W-1:WF], WF'($urandom)};
          else b = rand_op();
          send(a, b, 3'($urandom_range(0, 7)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e)
        $display("FAIL random_%0d: res=%b unord=%b min=%h max=%h required %b %b %h %h",
                 k, o.res, o.unord, o.mn, o.mx, e.res, e.unord, e.mn, e.mx);
      else n_pass++;
      $display("txn random %0d res=%b unord=%b min=%h max=%h", k, o.res, o.unord, o.mn, o.mx);
      k++;
    end
    n_checks++;
    if (k != 60 || obs_q.size() != 0)
      $display("FAIL random_count: delivered=%0d required 60", k + obs_q.size());
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    txn_t e;
    bit   stray = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; inA = rand_op(); inB = rand_op(); mode = 3'd2;
    @(posedge clk); #1;
    inA = rand_op(); inB = rand_op(); mode = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midreset_inflight: out_valid=%b required 1", out_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_async: out_valid=%b required 0", out_valid);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray || obs_q.size() != 0)
      $display("FAIL midreset_drop: stray valid=%b delivered=%0d required 0 0", stray, obs_q.size());
    else n_pass++;
    @(posedge clk); #1;
    a = mk(2'b01, 1'b1, 5'd20, 8'd3); b = mk(2'b01, 1'b0, 5'd2, 8'd9);
    e = model(a, b, 3'd1);
    in_valid = 1'b1; inA = a; inB = b; mode = 3'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_lat1: out_valid=%b required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || {result, unordered, min_out, max_out} !== e)
      $display("FAIL midreset_lat2: valid=%b res=%b min=%h max=%h required 1 %b %h %h",
               out_valid, result, min_out, max_out, e.res, e.mn, e.mx);
    else n_pass++;
    $display("txn postreset a=%h b=%h mode=1 res=%b", a, b, result);
    @(posedge clk); #1;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
